// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide execute unit that sits after the integer
//   register file. It retires one result bit per cycle with a radix-2
//   shift-add multiplier and a restoring divider. Divide-by-zero and signed
//   overflow skip the iterations and resolve in two cycles.
//
// Ports
//   clk      in   rising-edge clock
//   clr_n    in   asynchronous active-low reset
//   start    in   request, taken when the unit is idle or finishing
//   funct3   in   000 MUL 001 MULH 010 MULHSU 011 MULHU
//                 100 DIV 101 DIVU 110 REM 111 REMU
//   rs1data  in   operand A (multiplicand / dividend)
//   rs2data  in   operand B (multiplier / divisor)
//   rd_in    in   destination register index
//   flush    in   abort any operation in flight, with no write-back
//   busy     out  high from the accept edge until the done cycle ends
//   done     out  one-cycle result strobe
//   write    out  register-file write enable (done and rd != 0)
//   rd       out  destination index, held until the next result
//   rddata   out  result, held until the next result
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int RIDX = 5
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1data,
  input  logic [XLEN-1:0] rs2data,
  input  logic [RIDX-1:0] rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            write,
  output logic [RIDX-1:0] rd,
  output logic [XLEN-1:0] rddata
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_op;
  logic            r_fast, r_qneg, r_rneg;
  logic [XLEN-1:0] r_hi, r_lo, r_b;
  logic [RIDX-1:0] r_rd_pend, r_rd_hold;
  logic [XLEN-1:0] r_data_hold;

  // ---------------- operand decode at accept ----------------
  logic            w_accept, w_is_div, w_a_signed, w_b_signed;
  logic            w_a_neg, w_b_neg, w_b_zero, w_ovf, w_fast;
  logic [XLEN-1:0] w_mag_a, w_mag_b, w_fast_val;

  // The FIN cycle also accepts, so back-to-back requests keep done pulses
  // exactly one operation length apart.
  assign w_accept   = ((r_state == S_IDLE) || (r_state == S_FIN)) && start && !flush;
  assign w_is_div   = funct3[2];
  assign w_a_signed = w_is_div ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
  assign w_b_signed = w_is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
  assign w_a_neg    = w_a_signed & rs1data[XLEN-1];
  assign w_b_neg    = w_b_signed & rs2data[XLEN-1];
  assign w_mag_a    = w_a_neg ? -rs1data : rs1data;
  assign w_mag_b    = w_b_neg ? -rs2data : rs2data;
  assign w_b_zero   = (rs2data == '0);
  assign w_ovf      = w_is_div & ~funct3[0]
                    & (rs1data == {1'b1, {(XLEN-1){1'b0}}}) & (rs2data == '1);
  assign w_fast     = w_is_div & (w_b_zero | w_ovf);
  // funct3[1] selects remainder for divide ops.
  assign w_fast_val = w_b_zero ? (funct3[1] ? rs1data : '1)
                               : (funct3[1] ? '0 : rs1data);

  // ---------------- one radix-2 step ----------------
  logic [XLEN:0] w_sum, w_shift, w_trial;
  // Multiply: conditionally add the multiplicand into the upper half, then
  // shift the {carry, hi, lo} pair right; lo drains multiplier bits out.
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  // Divide: shift the next dividend bit into the partial remainder and try
  // subtracting the divisor; a set MSB in the trial means it borrowed.
  assign w_shift = {r_hi, r_lo[XLEN-1]};
  assign w_trial = w_shift - {1'b0, r_b};

  // ---------------- state register ----------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking ones would make results order-dependent.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = S_CALC;
      S_CALC: if (r_cnt == '0) w_next = S_FIN;
      S_FIN:  w_next = w_accept ? S_CALC : S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  // ---------------- result formation ----------------
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0]   w_quo, w_rem, w_result;

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = r_qneg ? -w_prod : w_prod;
  assign w_quo    = r_qneg ? -r_lo : r_lo;
  assign w_rem    = r_rneg ? -r_hi : r_hi;

  always_comb begin
    w_result = w_quo;
    if (r_fast)                  w_result = r_lo;
    else if (!r_op[2])           w_result = (r_op[1:0] == 2'b00) ? w_prod_s[XLEN-1:0]
                                                                 : w_prod_s[2*XLEN-1:XLEN];
    else if (r_op[1])            w_result = w_rem;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_cnt       <= '0;
      r_op        <= '0;
      r_fast      <= 1'b0;
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_b         <= '0;
      r_rd_pend   <= '0;
      r_rd_hold   <= '0;
      r_data_hold <= '0;
    end else begin
      if (r_state == S_FIN) begin
        r_rd_hold   <= r_rd_pend;
        r_data_hold <= w_result;
      end
      if (w_accept) begin
        r_op      <= funct3;
        r_rd_pend <= rd_in;
        r_fast    <= w_fast;
        r_qneg    <= w_a_neg ^ w_b_neg;
        r_rneg    <= w_a_neg;
        r_hi      <= '0;
        // Fast-path results park in CALC for a single cycle with no
        // iteration, so their strobe lands two cycles after accept.
        r_cnt     <= w_fast ? '0 : CW'(XLEN - 1);
        if (w_fast) begin
          r_lo <= w_fast_val;
          r_b  <= '0;
        end else if (w_is_div) begin
          r_lo <= w_mag_a;
          r_b  <= w_mag_b;
        end else begin
          r_lo <= w_mag_b;
          r_b  <= w_mag_a;
        end
      end else if (r_state == S_CALC) begin
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        if (!r_fast) begin
          if (!r_op[2]) begin
            r_hi <= w_sum[XLEN:1];
            r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
          end else if (!w_trial[XLEN]) begin
            r_hi <= w_trial[XLEN-1:0];
            r_lo <= {r_lo[XLEN-2:0], 1'b1};
          end else begin
            r_hi <= w_shift[XLEN-1:0];
            r_lo <= {r_lo[XLEN-2:0], 1'b0};
          end
        end
      end
    end
  end

  // ---------------- outputs ----------------
  // rd/rddata show the fresh result during FIN and the held copy otherwise.
  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_FIN);
  assign rd     = done ? r_rd_pend : r_rd_hold;
  assign rddata = done ? w_result : r_data_hold;
  assign write  = done & (r_rd_pend != '0);

endmodule
